// File: rtl/rect_flip_pkg.sv
// rect_flip_pkg: shared enums and the word flip function for the rectangle flip sequencer.
package rect_flip_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {
    FLIP_PASS = 2'b00,
    FLIP_BYTE = 2'b01,
    FLIP_BIT  = 2'b10,
    FLIP_INV  = 2'b11
  } flip_mode_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_RD,
    S_WAIT_RD,
    S_FLIP,
    S_REQ_WR,
    S_WAIT_WR,
    S_ADVANCE,
    S_DONE
  } state_t;
  // Works on any word up to MAX_W bits; callers pass their lane width and lane count.
  function automatic logic [MAX_W-1:0] flip_word(input logic [MAX_W-1:0] d, input flip_mode_t m,
                                                 input int dw, input int wb);
    logic [MAX_W-1:0] r;
    logic [5:0] j;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      j = m == FLIP_BYTE ? 6'((wb - 1 - i / dw) * dw + i % dw) : m == FLIP_BIT ? 6'(dw * wb - 1 - i) : 6'(i);
      if (i < dw * wb) r[i] = m == FLIP_INV ? ~d[i] : d[j];
    end
    return r;
  endfunction
endpackage

// File: rtl/rect_flip_ctrl_if.sv
// rect_flip_ctrl_if: request/response bus between the flip sequencer and the BRAM word adapter.
interface rect_flip_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int W          = 16
) ();
  logic                  st_read;
  logic                  st_write;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [W-1:0]          write_data;
  logic [W-1:0]          read_data;
  logic                  flip_ready;
  logic                  wrt_done;
  modport master (output st_read, st_write, base_addr, write_data, input read_data, flip_ready, wrt_done);
  modport slave  (input st_read, st_write, base_addr, write_data, output read_data, flip_ready, wrt_done);
endinterface

// File: rtl/rect_addr_gen.sv
// rect_addr_gen: row/col walk over the rectangle with incremental wrap-around address arithmetic.
module rect_addr_gen
  import rect_flip_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_BYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [3:0]            cols_i,
  input  logic [3:0]            rows_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);
  logic [3:0] cols_q, cols_d, rows_q, rows_d, col_q, col_d, row_q, row_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d, row_base_q, row_base_d, addr_q, addr_d;
  logic wrap;
  always_comb begin
    wrap       = col_q == cols_q - 4'd1;
    cols_d     = load_i ? cols_i : cols_q;
    rows_d     = load_i ? rows_i : rows_q;
    stride_d   = load_i ? stride_i : stride_q;
    col_d      = load_i ? 4'd0 : step_i ? (wrap ? 4'd0 : col_q + 4'd1) : col_q;
    row_d      = load_i ? 4'd0 : step_i && wrap ? row_q + 4'd1 : row_q;
    row_base_d = load_i ? base_i : step_i && wrap ? row_base_q + stride_q : row_base_q;
    addr_d     = load_i ? base_i :
                 step_i ? (wrap ? row_base_q + stride_q : addr_q + ADDR_WIDTH'(WORD_BYTES)) : addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q     <= '0;
      rows_q     <= '0;
      stride_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      cols_q     <= cols_d;
      rows_q     <= rows_d;
      stride_q   <= stride_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end
  assign addr_o = addr_q;
  assign last_o = wrap && row_q == rows_q - 4'd1;
endmodule

// File: rtl/rect_flip_ctrl.sv
// rect_flip_ctrl: walks a BRAM rectangle, flipping each word through the adapter with a watchdog.
// Optional FLIP_CHECKSUM_EN adds a checksum output: XOR of every word written in the job.
module rect_flip_ctrl
  import rect_flip_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_BYTES     = 2,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rect_base,
  input  logic [3:0]            rect_cols,
  input  logic [3:0]            rect_rows,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  input  logic [1:0]            flip_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            words_done,
  rect_flip_ctrl_if.master      bus
`ifdef FLIP_CHECKSUM_EN
  ,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] checksum
`endif
);
  localparam int W    = WORD_BYTES * DATA_WIDTH;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q;
  flip_mode_t mode_q;
  logic busy_q, done_q, err_q, st_read_q, st_write_q, last, load, step, empty;
  logic [7:0] words_q;
  logic [W-1:0] wdata_q, flipped;
  logic [WD_W-1:0] wd_q;
  logic [ADDR_WIDTH-1:0] addr;
`ifdef FLIP_CHECKSUM_EN
  logic [W-1:0] cks_q;
  assign checksum = cks_q;
`endif
  assign load    = state_q == S_IDLE && start;
  assign step    = state_q == S_ADVANCE;
  assign empty   = rect_cols == 4'd0 || rect_rows == 4'd0;
  assign flipped = W'(flip_word(MAX_W'(bus.read_data), mode_q, DATA_WIDTH, WORD_BYTES));
  rect_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_BYTES(WORD_BYTES)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .step_i  (step),
    .base_i  (rect_base),
    .cols_i  (rect_cols),
    .rows_i  (rect_rows),
    .stride_i(row_stride),
    .addr_o  (addr),
    .last_o  (last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= FLIP_PASS;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      st_read_q  <= 1'b0;
      st_write_q <= 1'b0;
      words_q    <= '0;
      wdata_q    <= '0;
      wd_q       <= '0;
`ifdef FLIP_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      st_read_q  <= 1'b0;
      st_write_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q    <= 1'b1;
          err_q     <= 1'b0;
          words_q   <= '0;
          mode_q    <= flip_mode_t'(flip_mode);
          st_read_q <= !empty;
          state_q   <= empty ? S_DONE : S_REQ_RD;
`ifdef FLIP_CHECKSUM_EN
          cks_q     <= '0;
`endif
        end
        S_REQ_RD: begin
          wd_q    <= WD_W'(TIMEOUT_CYCLES - 1);
          state_q <= S_WAIT_RD;
        end
        // Ready on the final watchdog cycle still wins over the timeout.
        S_WAIT_RD: if (bus.flip_ready) state_q <= S_FLIP;
          else if (wd_q == '0) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else wd_q <= wd_q - 1'b1;
        S_FLIP: begin
          wdata_q    <= flipped;
          st_write_q <= 1'b1;
          state_q    <= S_REQ_WR;
        end
        S_REQ_WR: begin
          wd_q    <= WD_W'(TIMEOUT_CYCLES - 1);
          state_q <= S_WAIT_WR;
        end
        S_WAIT_WR: if (bus.wrt_done) begin
            words_q <= words_q + 8'd1;
            state_q <= S_ADVANCE;
`ifdef FLIP_CHECKSUM_EN
            cks_q   <= cks_q ^ wdata_q;
`endif
          end else if (wd_q == '0) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else wd_q <= wd_q - 1'b1;
        S_ADVANCE: begin
          st_read_q <= !last;
          state_q   <= last ? S_DONE : S_REQ_RD;
        end
        default: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_done     = words_q;
  assign bus.st_read    = st_read_q;
  assign bus.st_write   = st_write_q;
  assign bus.base_addr  = addr;
  assign bus.write_data = wdata_q;
endmodule

// File: tb/tb_rect_flip_ctrl.sv
// tb_rect_flip_ctrl: directed bench with a BRAM adapter stub (read latency 2, write latency 3).
module tb_rect_flip_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] rect_base = '0, row_stride = '0;
  logic [3:0] rect_cols = '0, rect_rows = '0;
  logic [1:0] flip_mode = '0;
  logic busy, done, err;
  logic [7:0] words_done;
  logic hold_rd = 1'b0, hold_wr = 1'b0;
  logic [15:0] mem [256];
  logic [7:0] rd_addr, wr_addr, rd_log [$];
  logic [15:0] wr_data;
  int rd_cnt, wr_cnt, n_reads = 0, n_tests = 0, n_fail = 0, cyc, seen;
`ifdef FLIP_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  rect_flip_ctrl_if #(.ADDR_WIDTH(8), .W(16)) bus ();
  rect_flip_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .rect_base(rect_base), .rect_cols(rect_cols),
    .rect_rows(rect_rows), .row_stride(row_stride), .flip_mode(flip_mode), .busy(busy),
    .done(done), .err(err), .words_done(words_done), .bus(bus)
`ifdef FLIP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      bus.flip_ready <= 1'b0;
      bus.wrt_done   <= 1'b0;
      bus.read_data  <= '0;
      rd_cnt         <= -1;
      wr_cnt         <= -1;
    end else begin
      bus.flip_ready <= 1'b0;
      bus.wrt_done   <= 1'b0;
      if (bus.st_read) begin
        rd_addr <= bus.base_addr;
        rd_cnt  <= 1;
        n_reads <= n_reads + 1;
        rd_log.push_back(bus.base_addr);
      end else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
      else if (rd_cnt == 0) begin
        rd_cnt <= -1;
        if (!hold_rd) begin
          bus.flip_ready <= 1'b1;
          bus.read_data  <= mem[rd_addr];
        end
      end
      if (bus.st_write) begin
        wr_addr <= bus.base_addr;
        wr_data <= bus.write_data;
        wr_cnt  <= 2;
      end else if (wr_cnt > 0) wr_cnt <= wr_cnt - 1;
      else if (wr_cnt == 0) begin
        wr_cnt <= -1;
        if (!hold_wr) begin
          mem[wr_addr] <= wr_data;
          bus.wrt_done <= 1'b1;
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_job(input logic [7:0] b, input logic [3:0] c, input logic [3:0] r,
                         input logic [7:0] s, input logic [1:0] m);
    @(negedge clk);
    rect_base = b; rect_cols = c; rect_rows = r; row_stride = s; flip_mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done), 1);
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_words", 32'(words_done), 0);
    check("rst_bus", {bus.st_read, bus.st_write, bus.base_addr, bus.write_data}, 0);
    rst = 1'b0;
    mem[8'h10] <= 16'h1234; mem[8'h12] <= 16'hABCD;
    run_job(8'h10, 4'd2, 4'd1, 8'h00, 2'b01);
    check("t1_w0", 32'(mem[8'h10]), 32'h3412);
    check("t1_w1", 32'(mem[8'h12]), 32'hCDAB);
    check("t1_words", 32'(words_done), 2);
    check("t1_err_busy", {err, busy}, 0);
`ifdef FLIP_CHECKSUM_EN
    check("t1_checksum", 32'(checksum), 32'h3412 ^ 32'hCDAB);
`endif
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 0);
    rd_log.delete();
    mem[8'h00] <= 16'h0A0A; mem[8'h02] <= 16'h0B0B; mem[8'h10] <= 16'h0C0C; mem[8'h12] <= 16'h0D0D;
    run_job(8'h00, 4'd2, 4'd2, 8'h10, 2'b00);
    check("t2_nreads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("t2_a0", 32'(rd_log[0]), 32'h00);
      check("t2_a1", 32'(rd_log[1]), 32'h02);
      check("t2_a2", 32'(rd_log[2]), 32'h10);
      check("t2_a3", 32'(rd_log[3]), 32'h12);
    end
    check("t2_words", 32'(words_done), 4);
    check("t2_pass", 32'(mem[8'h12]), 32'h0D0D);
    mem[8'h20] <= 16'h0001; mem[8'h30] <= 16'h00FF;
    run_job(8'h20, 4'd1, 4'd1, 8'h00, 2'b10);
    check("t3_bitrev", 32'(mem[8'h20]), 32'h8000);
    run_job(8'h30, 4'd1, 4'd1, 8'h00, 2'b11);
    check("t3_invert", 32'(mem[8'h30]), 32'hFF00);
    rd_log.delete();
    mem[8'hFE] <= 16'h1111; mem[8'h00] <= 16'h2222;
    run_job(8'hFE, 4'd2, 4'd1, 8'h00, 2'b11);
    check("wrap_addr", 32'(rd_log.size() == 2 ? rd_log[1] : 8'hAA), 32'h00);
    check("wrap_w1", 32'(mem[8'h00]), 32'hDDDD);
    seen = n_reads;
    run_job(8'h40, 4'd3, 4'd0, 8'h00, 2'b00);
    check("t4_latency", cyc, 2);
    check("t4_no_read", n_reads - seen, 0);
    check("t4_words", 32'(words_done), 0);
    hold_rd = 1'b1;
    run_job(8'h40, 4'd1, 4'd1, 8'h00, 2'b00);
    check("t5_err", 32'(err), 1);
    check("t5_latency", cyc, 67);
    check("t5_words", 32'(words_done), 0);
    @(negedge clk);
    check("t5_err_sticky", 32'(err), 1);
    hold_rd = 1'b0;
    mem[8'h40] <= 16'h7777;
    run_job(8'h40, 4'd1, 4'd1, 8'h00, 2'b11);
    check("t5_err_clear", 32'(err), 0);
    check("t5_recover", 32'(mem[8'h40]), 32'h8888);
    hold_wr = 1'b1;
    mem[8'h50] <= 16'h5A5A;
    @(negedge clk);
    rect_base = 8'h50; rect_cols = 4'd1; rect_rows = 4'd1; flip_mode = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rect_cols = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_busy_held", {busy, done}, 2'b10);
    check("t6_wdata", 32'(bus.write_data), 32'hA5A5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold_wr = 1'b0;
    check("t6_rst_flags", {busy, done, err}, 0);
    check("t6_rst_words", 32'(words_done), 0);
    check("t6_rst_bus", {bus.st_read, bus.st_write, bus.base_addr, bus.write_data}, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(done);
    end
    check("t6_no_done", seen, 0);
    check("t6_mem_untouched", 32'(mem[8'h50]), 32'h5A5A);
    run_job(8'h50, 4'd1, 4'd1, 8'h00, 2'b01);
    check("t6_after_rst", 32'(mem[8'h50]), 32'h5A5A);
    check("t6_after_words", 32'(words_done), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
